// File: rtl/sensor_sched_pkg.sv
// Shared types and default constants for the sensor measurement scheduler.
package sensor_sched_pkg;

  localparam int DEF_DW              = 14;
  localparam int DEF_ROUND_CYC       = 25_000_000;
  localparam int DEF_DHT_EVERY       = 4;
  localparam int DEF_US_TIMEOUT_CYC  = 3_000_000;
  localparam int DEF_DHT_TIMEOUT_CYC = 4_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_US_START,
    ST_US_WAIT,
    ST_DHT_START,
    ST_DHT_WAIT
  } sched_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_round_timer.sv
// Round period generator: one tick every ROUND_CYC enabled cycles, plus an
// immediate tick on the first enabled cycle so a round starts without delay.
module sched_round_timer
  import sensor_sched_pkg::*;
#(
  parameter int ROUND_CYC = DEF_ROUND_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = cnt_width(ROUND_CYC);
  localparam logic [CW-1:0] LAST = CW'(ROUND_CYC - 1);

  logic [CW-1:0] cnt;
  logic          enable_seen;
  logic          wrap_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      enable_seen <= 1'b0;
      wrap_q      <= 1'b0;
    end else if (!enable) begin
      cnt         <= '0;
      enable_seen <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      enable_seen <= 1'b1;
      wrap_q      <= (cnt == LAST);
      cnt         <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // The wrap is registered so the period between ticks is exactly ROUND_CYC,
  // including the interval following the forced first tick.
  assign tick = enable && (wrap_q || !enable_seen);

endmodule

// File: rtl/sensor_scheduler.sv
// Time-multiplexed sequencer for the HC-SR04 and DHT11 controllers: starts one
// sensor at a time, waits for done or timeout and latches display results.
module sensor_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int ROUND_CYC       = DEF_ROUND_CYC,
  parameter int DHT_EVERY       = DEF_DHT_EVERY,
  parameter int US_TIMEOUT_CYC  = DEF_US_TIMEOUT_CYC,
  parameter int DHT_TIMEOUT_CYC = DEF_DHT_TIMEOUT_CYC,
  parameter int DW              = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          us_start,
  input  logic          us_done,
  input  logic [DW-1:0] us_distance,
  output logic          dht_start,
  input  logic          dht_done,
  input  logic          dht_chk_ok,
  input  logic [DW-1:0] dht_humidity,
  input  logic [DW-1:0] dht_temperature,
  output logic [DW-1:0] distance,
  output logic [DW-1:0] humidity,
  output logic [DW-1:0] temperature,
  output logic          us_err,
  output logic          dht_err,
  output logic          busy,
  output logic          overrun
);

  localparam int MAX_TO = (US_TIMEOUT_CYC > DHT_TIMEOUT_CYC) ? US_TIMEOUT_CYC
                                                             : DHT_TIMEOUT_CYC;
  localparam int WW = cnt_width(MAX_TO);
  localparam int IW = cnt_width(DHT_EVERY);

  localparam logic [WW-1:0] US_LAST  = WW'(US_TIMEOUT_CYC - 1);
  localparam logic [WW-1:0] DHT_LAST = WW'(DHT_TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DHT_EVERY - 1);

  sched_state_t  state, state_nx;
  logic          tick;
  logic          drop;
  logic          pending;
  logic [WW-1:0] wait_cnt;
  logic [IW-1:0] round_idx;
  logic          us_to, dht_to, us_end;

  sched_round_timer #(
    .ROUND_CYC (ROUND_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // A tick arriving while a round is queued or still running is discarded.
  assign drop   = tick && (pending || (state != ST_IDLE));
  assign us_to  = (wait_cnt == US_LAST);
  assign dht_to = (wait_cnt == DHT_LAST);
  assign us_end = (state == ST_US_WAIT) && (us_done || us_to);
  assign busy   = (state != ST_IDLE);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    us_start  = 1'b0;
    dht_start = 1'b0;
    case (state)
      ST_IDLE:      if (pending && enable) state_nx = ST_US_START;
      ST_US_START: begin
        us_start = 1'b1;
        state_nx = ST_US_WAIT;
      end
      ST_US_WAIT:   if (us_done || us_to)
                      state_nx = (round_idx == '0) ? ST_DHT_START : ST_IDLE;
      ST_DHT_START: begin
        dht_start = 1'b1;
        state_nx  = ST_DHT_WAIT;
      end
      ST_DHT_WAIT:  if (dht_done || dht_to) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending     <= 1'b0;
      overrun     <= 1'b0;
      wait_cnt    <= '0;
      round_idx   <= '0;
      distance    <= '0;
      humidity    <= '0;
      temperature <= '0;
      us_err      <= 1'b0;
      dht_err     <= 1'b0;
    end else begin
      overrun <= drop;

      if (!enable)             pending <= 1'b0;
      else if (tick && !drop)  pending <= 1'b1;
      else if (state == ST_IDLE) pending <= 1'b0;

      if ((state == ST_US_WAIT) || (state == ST_DHT_WAIT)) wait_cnt <= wait_cnt + WW'(1);
      else                                                  wait_cnt <= '0;

      if (us_end) round_idx <= (round_idx == IDX_LAST) ? '0 : round_idx + IW'(1);

      // Done is tested before the timeout, so a done on the last cycle wins.
      if (state == ST_US_WAIT) begin
        if (us_done) begin
          distance <= us_distance;
          us_err   <= 1'b0;
        end else if (us_to) begin
          us_err <= 1'b1;
        end
      end

      if (state == ST_DHT_WAIT) begin
        if (dht_done) begin
          if (dht_chk_ok) begin
            humidity    <= dht_humidity;
            temperature <= dht_temperature;
            dht_err     <= 1'b0;
          end else begin
            dht_err <= 1'b1;
          end
        end else if (dht_to) begin
          dht_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sensor_scheduler.md
Name: sensor_scheduler

Overview:
Time-multiplexed measurement sequencer for the sensor datapath. Periodically starts the HC-SR04 controller, then the DHT11 controller every DHT_EVERY rounds, so the two sensors never measure at once. Waits for each done or a timeout and latches results into display-ready registers for fnd_controller. Sits between the sensor controllers and the display mux in the top level.

Parameters:
ROUND_CYC, 25_000_000, clock cycles between round starts (250 ms at 100 MHz)
DHT_EVERY, 4, DHT11 is read on every DHT_EVERY-th round (min 1 s spacing)
US_TIMEOUT_CYC, 3_000_000, max cycles waiting for us_done
DHT_TIMEOUT_CYC, 4_000_000, max cycles waiting for dht_done
DW, 14, result width ($clog2(11600))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  scheduling enable
us_start  out  1  one-cycle start pulse to the ultrasonic controller
us_done  in  1  one-cycle pulse; us_distance valid
us_distance  in  DW  distance in cm
dht_start  out  1  one-cycle start pulse to the DHT11 controller
dht_done  in  1  one-cycle pulse; DHT data valid
dht_chk_ok  in  1  checksum good, sampled with dht_done
dht_humidity  in  DW  humidity
dht_temperature  in  DW  temperature
distance  out  DW  latched distance
humidity  out  DW  latched humidity
temperature  out  DW  latched temperature
us_err  out  1  last US transaction timed out
dht_err  out  1  last DHT transaction timed out or failed checksum
busy  out  1  state != IDLE
overrun  out  1  one-cycle pulse: round tick dropped

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0, state IDLE, timers 0, round index 0, pending 0. Applies mid-transaction; starts are not re-issued.
- Round timer: counts 0..ROUND_CYC-1 only while enable=1; cleared to 0 while enable=0. Wraps on ROUND_CYC-1 and emits tick. On the first cycle enable is seen high (timer==0, previously disabled) tick is forced, so the first round starts without a period wait.
- tick sets pending. If pending is already 1 or state != IDLE, the tick is dropped and overrun pulses 1 cycle.
- FSM states: IDLE, US_START, US_WAIT, DHT_START, DHT_WAIT.
- IDLE: if pending && enable -> clear pending -> US_START.
- US_START: us_start=1 for exactly 1 cycle; wait counter cleared -> US_WAIT.
- US_WAIT: on us_done, latch distance and clear us_err. At count US_TIMEOUT_CYC-1 without done, set us_err and hold distance. Next state is DHT_START if round_idx==0, else IDLE. round_idx increments mod DHT_EVERY on leaving US_WAIT.
- DHT_START: dht_start=1 for 1 cycle -> DHT_WAIT.
- DHT_WAIT: on dht_done with dht_chk_ok=1, latch humidity and temperature and clear dht_err. On dht_done with chk_ok=0, set dht_err and hold values. On timeout, set dht_err and hold values. Then -> IDLE.
- Done and timeout in the same cycle: done wins.
- done pulses outside their WAIT state are ignored.
- enable falls mid-round: the current transaction completes, including DHT if scheduled. Pending is cleared, then the FSM stays in IDLE.
- Latency: us_start is high 2 cycles after tick. Output registers update the cycle after done.

Decomposition:
- Package sensor_sched_pkg: state enum, DW, default cycle constants.
- One sub-module, sched_round_timer: round counter, forced first tick, tick output.
- Wait counter and FSM stay in the top of this block.

Test Plan:
- Params ROUND_CYC=100, DHT_EVERY=2, US_TIMEOUT_CYC=20, DHT_TIMEOUT_CYC=30. Raise enable; us_done at +5 with distance=123 -> us_start at cycle 2; distance=123; dht_start follows; dht_done+chk_ok with 45/27 -> humidity=45, temperature=27, errs 0.
- Second round (tick at 100) -> us_start only, no dht_start. Third round -> both.
- Withhold us_done -> us_err=1 exactly 20 cycles after US_WAIT entry; distance unchanged; next state DHT_START or IDLE per round_idx.
- dht_done with chk_ok=0 and values 99/99 -> dht_err=1; humidity and temperature keep prior 45/27.
- Hold us_done off with US_TIMEOUT_CYC=150 across a tick -> overrun pulses once; next round starts on the following tick.
- Assert reset low during DHT_WAIT -> next edge all outputs 0, busy=0. A late dht_done is ignored.
